// File: rtl/actor_move_scheduler.sv
// Actor movement scheduler: on each tick, walks Pac-Man and the four ghosts in
// order. For each actor it computes the target block, reads the block type
// through the shared board RAM port, and commits the move unless it is a wall.
module actor_move_scheduler #(
  parameter int                      COLS      = 32,
  parameter int                      ROWS      = 24,
  parameter int                      N_ACTORS  = 5,
  parameter logic [3:0]              WALL_TYPE = 4'd1,
  parameter logic [10*N_ACTORS-1:0]  INIT_LOCS = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [N_ACTORS-1:0]     dir_valid,
  input  logic [2*N_ACTORS-1:0]   dir,
  output logic                    ram_req,
  output logic [9:0]              ram_addr,
  input  logic                    ram_gnt,
  input  logic [3:0]              ram_q,
  output logic [10*N_ACTORS-1:0]  loc,
  output logic [N_ACTORS-1:0]     blocked,
  output logic                    busy,
  output logic                    done,
  output logic                    tick_missed
);

  localparam int         IW     = (N_ACTORS > 1) ? $clog2(N_ACTORS) : 1;
  localparam logic [9:0] COLS10 = 10'(COLS);
  localparam logic [9:0] ROWS10 = 10'(ROWS);

  typedef enum logic [2:0] {IDLE, CALC, REQ, CHECK, DONE} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx;
  logic [9:0]              loc_r [N_ACTORS];
  logic [N_ACTORS-1:0]     blocked_r;
  logic [N_ACTORS-1:0]     dv_sh;
  logic [2*N_ACTORS-1:0]   dir_sh;
  logic [9:0]              addr_r;

  logic [9:0]              cur_loc;
  logic [9:0]              cur_row;
  logic [9:0]              cur_col;
  logic [1:0]              cur_dir;
  logic                    cur_dv;
  logic                    edge_blk;
  logic [9:0]              target;
  logic                    last;

  // Target computation for the actor selected by idx; tunnel wraps are explicit.
  always_comb begin
    cur_loc  = loc_r[idx];
    cur_dv   = dv_sh[idx];
    cur_dir  = dir_sh[2*int'(idx) +: 2];
    cur_row  = cur_loc / COLS10;
    cur_col  = cur_loc % COLS10;
    edge_blk = 1'b0;
    target   = cur_loc;
    case (cur_dir)
      2'b00: begin
        edge_blk = (cur_row == 10'd0);
        target   = cur_loc - COLS10;
      end
      2'b01: begin
        edge_blk = (cur_row == ROWS10 - 10'd1);
        target   = cur_loc + COLS10;
      end
      2'b10: target = (cur_col == 10'd0) ? cur_loc + (COLS10 - 10'd1)
                                         : cur_loc - 10'd1;
      default: target = (cur_col == COLS10 - 10'd1) ? cur_loc - (COLS10 - 10'd1)
                                                    : cur_loc + 10'd1;
    endcase
    last = (idx == IW'(N_ACTORS - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = CALC;
      CALC:    if (!cur_dv || edge_blk) state_nxt = last ? DONE : CALC;
               else                     state_nxt = REQ;
      REQ:     if (ram_gnt) state_nxt = CHECK;
      CHECK:   state_nxt = last ? DONE : CALC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: shadow directions, actor index, target address, locations, blocked flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_ACTORS; i++) loc_r[i] <= INIT_LOCS[10*i +: 10];
      blocked_r <= '0;
      addr_r    <= '0;
      idx       <= '0;
      dv_sh     <= '0;
      dir_sh    <= '0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          dv_sh  <= dir_valid;
          dir_sh <= dir;
          idx    <= '0;
        end
        CALC: begin
          if (!cur_dv) begin
            blocked_r[idx] <= 1'b0;
            if (!last) idx <= idx + 1'b1;
          end else if (edge_blk) begin
            blocked_r[idx] <= 1'b1;
            if (!last) idx <= idx + 1'b1;
          end else begin
            addr_r <= target;
          end
        end
        CHECK: begin
          // addr_r still holds this actor's target, so it doubles as the new location.
          if (ram_q == WALL_TYPE) begin
            blocked_r[idx] <= 1'b1;
          end else begin
            blocked_r[idx] <= 1'b0;
            loc_r[idx]     <= addr_r;
          end
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode and location packing.
  always_comb begin
    loc = '0;
    for (int unsigned i = 0; i < N_ACTORS; i++) loc[10*i +: 10] = loc_r[i];
    blocked     = blocked_r;
    ram_addr    = addr_r;
    ram_req     = (state == REQ);
    busy        = (state != IDLE);
    done        = (state == DONE);
    tick_missed = tick && (state != IDLE);
  end

endmodule

// File: tb/tb_actor_move_scheduler.sv
// Bench for actor_move_scheduler: a round-level model predicts the RAM address
// sequence, final locations/blocked flags and the done cycle; a per-cycle
// compare process checks the DUT against it, plus literal expectations.
module tb_actor_move_scheduler;
  localparam int COLS = 32;
  localparam int ROWS = 24;
  localparam int NA   = 5;
  localparam logic [49:0] INIT = {10'd700, 10'd200, 10'd100, 10'd5, 10'd33};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [4:0]  dir_valid = '0;
  logic [9:0]  dir = '0;
  logic        ram_req;
  logic [9:0]  ram_addr;
  logic        ram_gnt = 1'b1;
  logic [3:0]  ram_q = '0;
  logic [49:0] loc;
  logic [4:0]  blocked;
  logic        busy, done, tick_missed;

  actor_move_scheduler #(
    .COLS(COLS), .ROWS(ROWS), .N_ACTORS(NA), .WALL_TYPE(4'd1), .INIT_LOCS(INIT)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .dir_valid(dir_valid), .dir(dir),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_gnt(ram_gnt), .ram_q(ram_q),
    .loc(loc), .blocked(blocked), .busy(busy), .done(done), .tick_missed(tick_missed)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  int cyc = 0;
  logic [3:0] board [768];
  int m_loc [NA];
  int m_next [NA];
  logic [4:0] m_blk = '0, m_bnext = '0;
  int exp_addr [$];
  bit pending = 1'b0;
  int exp_done_cyc = -1, exp_missed_cyc = -1;
  int stall_left = 0;
  int n_grants = 0, n_req_cycles = 0, n_missed = 0;
  int t0 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic note_fail(input string name, input int act, input int exp);
    n_tot++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Arbiter model: withholds the grant for stall_left request cycles.
  always @(posedge clk) begin
    #2;
    if (ram_req && stall_left > 0) begin
      ram_gnt = 1'b0;
      stall_left--;
    end else begin
      ram_gnt = 1'b1;
    end
  end

  // Board RAM: data appears the cycle after the grant cycle.
  always @(posedge clk) if (ram_req && ram_gnt) ram_q <= board[ram_addr];

  // Per-cycle compare against the round model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("tick_missed", int'(tick_missed), (cyc == exp_missed_cyc) ? 1 : 0);
      if (tick_missed) n_missed++;
      if (ram_req) begin
        n_req_cycles++;
        if (exp_addr.size() == 0) note_fail("unexpected_req", int'(ram_addr), -1);
        else begin
          chk("ram_addr", int'(ram_addr), exp_addr[0]);
          if (ram_gnt) begin
            void'(exp_addr.pop_front());
            n_grants++;
          end
        end
      end
      if (done) begin
        if (!pending) note_fail("unexpected_done", 1, 0);
        else begin
          chk("done_cycle", cyc, exp_done_cyc);
          chk("addr_drained", exp_addr.size(), 0);
          m_loc   = m_next;
          m_blk   = m_bnext;
          pending = 1'b0;
        end
      end
      if (!busy) begin
        for (int i = 0; i < NA; i++) chk($sformatf("loc%0d", i), int'(loc[10*i +: 10]), m_loc[i]);
        chk("blocked", int'(blocked), int'(m_blk));
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_loc[i]  = int'(INIT[10*i +: 10]);
      m_next[i] = m_loc[i];
    end
    m_blk   = '0;
    m_bnext = '0;
    exp_addr.delete();
    pending = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Predicts the whole round from row/col arithmetic, then issues the tick.
  task automatic start_round(input logic [4:0] dv, input logic [9:0] d,
                             input int stall, input int miss_off);
    int cost, r, c, nr, nc, tgt;
    bit first, ok;
    cost = 0;
    first = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < NA; i++) begin
      m_next[i]  = m_loc[i];
      m_bnext[i] = 1'b0;
      if (!dv[i]) begin
        cost += 1;
      end else begin
        r = m_loc[i] / COLS;
        c = m_loc[i] % COLS;
        nr = r; nc = c; ok = 1'b1;
        case (d[2*i +: 2])
          2'b00: if (r == 0) ok = 1'b0; else nr = r - 1;
          2'b01: if (r == ROWS - 1) ok = 1'b0; else nr = r + 1;
          2'b10: nc = (c + COLS - 1) % COLS;
          default: nc = (c + 1) % COLS;
        endcase
        if (!ok) begin
          m_bnext[i] = 1'b1;
          cost += 1;
        end else begin
          tgt = nr * COLS + nc;
          exp_addr.push_back(tgt);
          cost += 3 + (first ? stall : 0);
          first = 1'b0;
          if (board[tgt] == 4'd1) m_bnext[i] = 1'b1;
          else m_next[i] = tgt;
        end
      end
    end
    exp_done_cyc   = t0 + cost + 1;
    exp_missed_cyc = (miss_off > 0) ? t0 + miss_off : -1;
    stall_left     = stall;
    pending        = 1'b1;
    dir_valid      = dv;
    dir            = d;
    tick           = 1'b1;
    @(posedge clk); #1;
    tick      = 1'b0;
    dir_valid = ~dv;
    dir       = ~d;
    if (miss_off > 0) begin
      repeat (miss_off - 1) @(posedge clk);
      #1;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300 && pending; k++) @(posedge clk);
    if (pending) begin
      note_fail("done_timeout", 0, 1);
      pending = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  int g0, q0, mi0;

  initial begin
    for (int i = 0; i < 768; i++) board[i] = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_loc0", int'(loc[9:0]), 33);
    chk("rst_loc1", int'(loc[19:10]), 5);
    chk("rst_blocked", int'(blocked), 0);
    chk("rst_ram_req", int'(ram_req), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // 1: open move right
    g0 = n_grants;
    start_round(5'b00001, 10'b00_00_00_00_11, 0, 0);
    chk("t1_done_offset", exp_done_cyc - t0, 8);
    wait_done();
    chk("t1_loc0", int'(loc[9:0]), 34);
    chk("t1_blocked0", int'(blocked[0]), 0);
    chk("t1_grants", n_grants - g0, 1);

    // 2: wall
    do_reset();
    board[34] = 4'd1;
    g0 = n_grants;
    start_round(5'b00001, 10'b00_00_00_00_11, 0, 0);
    wait_done();
    chk("t2_loc0", int'(loc[9:0]), 33);
    chk("t2_blocked0", int'(blocked[0]), 1);
    chk("t2_grants", n_grants - g0, 1);
    board[34] = 4'd0;

    // 3: walk to 160, then tunnel left and top-edge block for actor 1
    start_round(5'b00001, 10'b00_00_00_00_10, 0, 0);
    wait_done();
    chk("t3_loc0_32", int'(loc[9:0]), 32);
    for (int k = 0; k < 4; k++) begin
      start_round(5'b00001, 10'b00_00_00_00_01, 0, 0);
      wait_done();
    end
    chk("t3_loc0_160", int'(loc[9:0]), 160);
    g0 = n_grants;
    q0 = n_req_cycles;
    start_round(5'b00011, 10'b00_00_00_00_10, 0, 0);
    wait_done();
    chk("t3_loc0_191", int'(loc[9:0]), 191);
    chk("t3_blocked1", int'(blocked[1]), 1);
    chk("t3_req_cycles", n_req_cycles - q0, 1);

    // 4: all actors move, grant withheld 3 cycles for actor 0
    q0 = n_req_cycles;
    start_round(5'b11111, 10'b11_10_00_01_11, 3, 0);
    chk("t4_done_offset", exp_done_cyc - t0, 19);
    wait_done();
    chk("t4_loc0", int'(loc[9:0]), 160);
    chk("t4_loc1", int'(loc[19:10]), 37);
    chk("t4_loc2", int'(loc[29:20]), 68);
    chk("t4_loc3", int'(loc[39:30]), 199);
    chk("t4_loc4", int'(loc[49:40]), 701);
    chk("t4_blocked", int'(blocked), 0);
    chk("t4_req_cycles", n_req_cycles - q0, 8);

    // 5: tick while busy at t+5
    mi0 = n_missed;
    start_round(5'b00001, 10'b00_00_00_00_11, 0, 5);
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    chk("t5_missed", n_missed - mi0, 1);
    chk("t5_loc0", int'(loc[9:0]), 161);

    // 5b: empty round, tick coinciding with done
    mi0 = n_missed;
    start_round(5'b00000, 10'b00_00_00_00_00, 0, 6);
    chk("t5b_done_offset", exp_done_cyc - t0, 6);
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    chk("t5b_missed", n_missed - mi0, 1);
    chk("t5b_busy", int'(busy), 0);

    // 6: reset mid-round after actor 0 has moved
    start_round(5'b00001, 10'b00_00_00_00_01, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_moved_loc0", int'(loc[9:0]), 193);
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_ram_req", int'(ram_req), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_loc0", int'(loc[9:0]), 33);
    chk("t6_blocked", int'(blocked), 0);
    repeat (20) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
